// File: rtl/quad_pkg.sv
// Shared decode constants and helpers for the quadrature decoder and its input filters.
// Pure declarations: no logic, no latency.
package quad_pkg;

    localparam int MODE_X1 = 1;
    localparam int MODE_X2 = 2;
    localparam int MODE_X4 = 4;

    // Next AB state in the forward (+1) Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] quad_fwd(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    // Filter counter width, $clog2(FILTER_LEN+1), evaluated per instance.
    function automatic int filt_cnt_w(input int filter_len);
        return (filter_len < 1) ? 1 : $clog2(filter_len + 1);
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchroniser plus stable-count glitch filter for one encoder pin.
// Latency: 2 sync cycles plus FILTER_LEN stable cycles; no backpressure.
module quad_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter bit REST       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int              CW   = filt_cnt_w(FILTER_LEN);
    localparam logic [CW-1:0]   LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= REST;
            r_sync2 <= REST;
            r_filt  <= REST;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any cycle where the synchronised level agrees restarts the stability count.
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B -> 1x/2x/4x position count with wrap/saturate and preload.
// Latency: pin to outputs FILTER_LEN+3 cycles, load to value 1 cycle; no backpressure.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               FILTER_LEN  = 4,
    parameter int               MODE        = 1,
    parameter bit               SATURATE    = 1'b0,
    parameter bit               REST_A      = 1'b1,
    parameter bit               REST_B      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             sat,
    output logic             err
);

    generate
        if (MODE != MODE_X1 && MODE != MODE_X2 && MODE != MODE_X4) begin : g_bad_mode
            $error("quad_decoder: MODE must be 1, 2 or 4");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("quad_decoder: WIDTH must be at least 2");
        end
        if (FILTER_LEN < 1) begin : g_bad_filter
            $error("quad_decoder: FILTER_LEN must be at least 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic             w_a_filt;
    logic             w_b_filt;
    logic [1:0]       w_cur;
    logic [1:0]       w_diff;
    logic             w_illegal;
    logic             w_fwd;
    logic             w_count;
    logic             w_at_limit;

    logic [1:0]       r_prev;
    logic [WIDTH-1:0] r_value;
    logic             r_step;
    logic             r_dir;
    logic             r_sat;
    logic             r_err;

    quad_filter #(.FILTER_LEN(FILTER_LEN), .REST(REST_A)) u_filt_a (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (a_in),
        .o_filt (w_a_filt)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN), .REST(REST_B)) u_filt_b (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (b_in),
        .o_filt (w_b_filt)
    );

    assign w_cur     = {w_a_filt, w_b_filt};
    assign w_diff    = w_cur ^ r_prev;
    assign w_illegal = &w_diff;
    assign w_fwd     = (quad_fwd(r_prev) == w_cur);

    // Resolution selects which legal transitions produce a count; X1 counts A rising only.
    always_comb begin
        w_count = 1'b0;
        if (!w_illegal && (w_diff != 2'b00)) begin
            case (MODE)
                MODE_X4: w_count = 1'b1;
                MODE_X2: w_count = w_diff[1];
                default: w_count = w_diff[1] & w_cur[1];
            endcase
        end
    end

    assign w_at_limit = SATURATE && (w_fwd ? (r_value == MAX_VAL) : (r_value == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= {REST_A, REST_B};
            r_value <= RESET_VALUE;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_prev <= w_cur;
            r_err  <= w_illegal;
            r_step <= 1'b0;
            r_sat  <= 1'b0;
            // Preload wins outright: a coincident count leaves no trace on step/dir/sat.
            if (load) begin
                r_value <= load_value;
            end else if (w_count) begin
                r_step <= 1'b1;
                r_dir  <= w_fwd;
                if (w_at_limit) begin
                    r_sat <= 1'b1;
                end else if (w_fwd) begin
                    r_value <= r_value + WIDTH'(1);
                end else begin
                    r_value <= r_value - WIDTH'(1);
                end
            end
        end
    end

    assign value = r_value;
    assign step  = r_step;
    assign dir   = r_dir;
    assign sat   = r_sat;
    assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench: three decoder configurations share one pin stream; a Gray-position
// reference model predicts every output event, a negedge monitor pops and compares.
module tb_quad_decoder;

    localparam int W   = 4;
    localparam int F   = 3;
    localparam int N   = 3;
    localparam int LAT = F + 3;

    typedef struct packed {
        logic [W-1:0] value;
        logic         dir;
        logic         step;
        logic         sat;
        logic         err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                a_in;
    logic                b_in;
    logic                load;
    logic [W-1:0]        load_value;
    logic [N-1:0][W-1:0] val_w;
    logic [N-1:0]        step_w;
    logic [N-1:0]        dir_w;
    logic [N-1:0]        sat_w;
    logic [N-1:0]        err_w;

    exp_t       exp_q [N][$];
    int         m_val [N];
    bit         m_dir [N];
    logic [1:0] m_ab;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    quad_decoder #(.WIDTH(W), .FILTER_LEN(F), .MODE(4), .SATURATE(1'b0),
                   .REST_A(1'b1), .REST_B(1'b1), .RESET_VALUE(4'd0)) u_x4 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .load(load), .load_value(load_value),
        .value(val_w[0]), .step(step_w[0]), .dir(dir_w[0]), .sat(sat_w[0]), .err(err_w[0]));

    quad_decoder #(.WIDTH(W), .FILTER_LEN(F), .MODE(2), .SATURATE(1'b1),
                   .REST_A(1'b1), .REST_B(1'b1), .RESET_VALUE(4'd5)) u_x2 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .load(load), .load_value(load_value),
        .value(val_w[1]), .step(step_w[1]), .dir(dir_w[1]), .sat(sat_w[1]), .err(err_w[1]));

    quad_decoder #(.WIDTH(W), .FILTER_LEN(F), .MODE(1), .SATURATE(1'b0),
                   .REST_A(1'b1), .REST_B(1'b1), .RESET_VALUE(4'd15)) u_x1 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .load(load), .load_value(load_value),
        .value(val_w[2]), .step(step_w[2]), .dir(dir_w[2]), .sat(sat_w[2]), .err(err_w[2]));

    function automatic int mode_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic bit sat_of(input int k);
        return (k == 1);
    endfunction

    function automatic int rstv_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 5 : 15);
    endfunction

    // Position of an AB state around the forward Gray circle.
    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_at(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, required %0d", nm, k, got, req);
        end
    endtask

    task automatic model_reset();
        m_ab = 2'b11;
        for (int k = 0; k < N; k++) begin
            m_val[k] = rstv_of(k);
            m_dir[k] = 1'b0;
        end
    endtask

    // Predict the outcome of the filtered AB moving from m_ab to nab in every configuration.
    task automatic model_move(input logic [1:0] nab);
        int   d;
        int   nv;
        int   maxv;
        bit   counts;
        exp_t e;
        maxv = (1 << W) - 1;
        d = (gpos(nab) - gpos(m_ab) + 4) % 4;
        for (int k = 0; k < N; k++) begin
            counts = 1'b0;
            e      = '0;
            if (d == 2) begin
                e.value = W'(m_val[k]);
                e.dir   = m_dir[k];
                e.err   = 1'b1;
                exp_q[k].push_back(e);
            end else if (d != 0) begin
                case (mode_of(k))
                    4:       counts = 1'b1;
                    2:       counts = (nab[1] != m_ab[1]);
                    default: counts = (!m_ab[1] && nab[1]);
                endcase
                if (counts) begin
                    nv = m_val[k] + ((d == 1) ? 1 : -1);
                    if (nv < 0 || nv > maxv) begin
                        if (sat_of(k)) begin
                            nv    = m_val[k];
                            e.sat = 1'b1;
                        end else begin
                            nv = (nv + maxv + 1) % (maxv + 1);
                        end
                    end
                    m_val[k] = nv;
                    m_dir[k] = (d == 1);
                    e.value  = W'(nv);
                    e.dir    = m_dir[k];
                    e.step   = 1'b1;
                    exp_q[k].push_back(e);
                end
            end
        end
        m_ab = nab;
    endtask

    task automatic drive_move(input logic [1:0] nab, input int hold);
        model_move(nab);
        a_in = nab[1];
        b_in = nab[0];
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet();
        repeat (LAT + 2) @(posedge clk);
        #1;
    endtask

    task automatic glitch(input bit on_a, input int len);
        if (on_a) a_in = ~a_in; else b_in = ~b_in;
        repeat (len) @(posedge clk);
        #1;
        if (on_a) a_in = ~a_in; else b_in = ~b_in;
        repeat (F + 2) @(posedge clk);
        #1;
    endtask

    task automatic quiet_load(input logic [W-1:0] v);
        wait_quiet();
        load       = 1'b1;
        load_value = v;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int k = 0; k < N; k++) m_val[k] = v;
        @(negedge clk);
        for (int k = 0; k < N; k++) chk("quiet_load_value", k, val_w[k], v);
        @(posedge clk);
        #1;
    endtask

    // Forward move whose decoder edge coincides with load: the count must vanish.
    task automatic coincident_load(input logic [W-1:0] v);
        logic [1:0] nab;
        wait_quiet();
        nab  = gray_at(gpos(m_ab) + 1);
        m_ab = nab;
        for (int k = 0; k < N; k++) m_val[k] = v;
        a_in = nab[1];
        b_in = nab[0];
        repeat (LAT - 1) @(posedge clk);
        #1;
        load       = 1'b1;
        load_value = v;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) chk("coincident_load_value", k, val_w[k], v);
        repeat (F + 2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string nm);
        for (int k = 0; k < N; k++) begin
            chk({nm, "_value"}, k, val_w[k], rstv_of(k));
            chk({nm, "_flags"}, k, {step_w[k], dir_w[k], sat_w[k], err_w[k]}, 0);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t got;
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (step_w[k] || sat_w[k] || err_w[k]) begin
                got = {val_w[k], dir_w[k], step_w[k], sat_w[k], err_w[k]};
                checks++;
                if (exp_q[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event dut%0d: got val=%0d dir=%0b step=%0b sat=%0b err=%0b, required no event",
                             k, got.value, got.dir, got.step, got.sat, got.err);
                end else begin
                    e = exp_q[k].pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL event dut%0d: got val=%0d dir=%0b step=%0b sat=%0b err=%0b, required val=%0d dir=%0b step=%0b sat=%0b err=%0b",
                                 k, got.value, got.dir, got.step, got.sat, got.err,
                                 e.value, e.dir, e.step, e.sat, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int r;
        logic [1:0] nab;
        logic [W-1:0] lv;

        rst        = 1'b1;
        a_in       = 1'b1;
        b_in       = 1'b1;
        load       = 1'b0;
        load_value = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // First event latency from pin change.
        @(posedge clk);
        #1;
        model_move(2'b10);
        a_in = 1'b1;
        b_in = 1'b0;
        lat  = 0;
        while (!step_w[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("first_step_latency", 0, lat, LAT);
        repeat (F + 2) @(posedge clk);
        #1;

        // Four full forward Gray cycles, then one reverse cycle.
        for (int i = 1; i <= 16; i++) drive_move(gray_at(3 + i), F + 2);
        for (int i = 1; i <= 4; i++) drive_move(gray_at(3 + 4 - i), F + 2);

        // Saturation at both ends.
        quiet_load(4'hF);
        for (int i = 1; i <= 4; i++) drive_move(gray_at(gpos(m_ab) + 1), F + 2);
        quiet_load(4'h0);
        for (int i = 1; i <= 4; i++) drive_move(gray_at(gpos(m_ab) + 3), F + 2);

        // Sub-threshold glitches followed by an illegal double change.
        wait_quiet();
        glitch(1'b1, F - 1);
        glitch(1'b0, 1);
        drive_move(~m_ab, F + 6);

        coincident_load(4'hA);

        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 11);
            if (r <= 6) begin
                nab = gray_at(gpos(m_ab) + (($urandom_range(0, 1) == 1) ? 1 : 3));
                drive_move(nab, $urandom_range(F + 2, F + 5));
            end else if (r == 7) begin
                drive_move(~m_ab, $urandom_range(F + 2, F + 5));
            end else if (r == 8) begin
                glitch($urandom_range(0, 1) == 1, $urandom_range(1, F - 1));
            end else if (r == 9 || r == 10) begin
                case ($urandom_range(0, 2))
                    0:       lv = '0;
                    1:       lv = '1;
                    default: lv = W'($urandom_range(0, (1 << W) - 1));
                endcase
                quiet_load(lv);
            end else begin
                coincident_load(W'($urandom_range(0, (1 << W) - 1)));
            end
        end

        // Reset while a transition is still inside the filters.
        wait_quiet();
        nab  = gray_at(gpos(m_ab) + 1);
        a_in = nab[1];
        b_in = nab[0];
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        a_in = 1'b1;
        b_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_state("mid_rotation_reset");
        repeat (LAT + 6) @(posedge clk);
        #1;

        // A short post-reset rotation confirms counting resumes from the reset value.
        for (int i = 1; i <= 6; i++) drive_move(gray_at(2 + i), F + 2);

        wait_quiet();
        for (int k = 0; k < N; k++) begin
            chk("queue_drained", k, exp_q[k].size(), 0);
            chk("final_value", k, val_w[k], m_val[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
